// File: rtl/register_file.sv
// rtl/register_file.sv - integer register file with post-reset clear sequencer and write-to-read bypass
module register_file #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ID_RegWrite,
  input  logic [ADDR_W-1:0] ID_RD,
  input  logic [XLEN-1:0]   ID_RegWriteData,
  input  logic [ADDR_W-1:0] RS1,
  input  logic [ADDR_W-1:0] RS2,
  output logic [XLEN-1:0]   ReadData1,
  output logic [XLEN-1:0]   ReadData2,
  output logic              Busy
);

  typedef enum logic {CLEAR, READY} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] clr_idx;
  logic [XLEN-1:0]   regs [NUM_REGS];
  logic              ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_idx <= FIRST_IDX;
    end else if (state == CLEAR) begin
      clr_idx <= clr_idx + FIRST_IDX;
      if (clr_idx == LAST_IDX)
        state <= READY;
    end
  end

  // Array is never reset; the sequencer zeroes it instead, and entry 0 is never written.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CLEAR)
        regs[clr_idx] <= '0;
      else if (ID_RegWrite && (ID_RD != '0))
        regs[ID_RD] <= ID_RegWriteData;
    end
  end

  assign ready = rst_n && (state == READY);
  assign Busy  = !ready;

  always_comb begin
    ReadData1 = '0;
    if (ready && (RS1 != '0)) begin
      if (ID_RegWrite && (ID_RD == RS1))
        ReadData1 = ID_RegWriteData;
      else
        ReadData1 = regs[RS1];
    end
  end

  always_comb begin
    ReadData2 = '0;
    if (ready && (RS2 != '0)) begin
      if (ID_RegWrite && (ID_RD == RS2))
        ReadData2 = ID_RegWriteData;
      else
        ReadData2 = regs[RS2];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - scoreboard bench for register_file
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ID_RegWrite = 1'b0;
  logic [4:0]  ID_RD = '0;
  logic [31:0] ID_RegWriteData = '0;
  logic [4:0]  RS1 = '0;
  logic [4:0]  RS2 = '0;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic        Busy;

  register_file dut (
    .clk(clk), .rst_n(rst_n), .ID_RegWrite(ID_RegWrite), .ID_RD(ID_RD),
    .ID_RegWriteData(ID_RegWriteData), .RS1(RS1), .RS2(RS2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .Busy(Busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        busy;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_regs [32];
  logic        m_busy = 1'b1;
  int          m_idx = 1;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] rs, input logic wr,
                                         input logic [4:0] rd, input logic [31:0] wd);
    if (rs == 0) return 32'h0;
    if (wr && rd == rs) return wd;
    return m_regs[rs];
  endfunction

  // One clock: drive at negedge, compare before the next posedge, then advance the model.
  task automatic step(input logic rst, input logic wr, input logic [4:0] rd, input logic [31:0] wd,
                      input logic [4:0] r1, input logic [4:0] r2,
                      output logic b, output logic [31:0] o1, output logic [31:0] o2);
    exp_t e;
    @(negedge clk);
    rst_n = rst; ID_RegWrite = wr; ID_RD = rd; ID_RegWriteData = wd; RS1 = r1; RS2 = r2;
    if (!rst || m_busy) e = '{busy: 1'b1, d1: 32'h0, d2: 32'h0};
    else e = '{busy: 1'b0, d1: m_read(r1, wr, rd, wd), d2: m_read(r2, wr, rd, wd)};
    sb.push_back(e);
    #2;
    b = Busy; o1 = ReadData1; o2 = ReadData2;
    e = sb.pop_front();
    check("busy", {31'h0, Busy}, {31'h0, e.busy});
    check("rd1", ReadData1, e.d1);
    check("rd2", ReadData2, e.d2);
    if (!rst) begin
      m_busy = 1'b1; m_idx = 1;
    end else if (m_busy) begin
      m_regs[m_idx] = 32'h0;
      if (m_idx == 31) m_busy = 1'b0;
      m_idx++;
    end else if (wr && rd != 0) begin
      m_regs[rd] = wd;
    end
  endtask

  task automatic count_clear(input string tag);
    logic b;
    logic [31:0] o1, o2;
    int n = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, b, o1, o2);
      if (!b) break;
      n++;
    end
    check(tag, 32'(n), 32'd31);
  endtask

  initial begin
    logic b;
    logic [31:0] o1, o2;

    step(1'b0, 1'b1, 5'd4, 32'h1111, 5'd4, 5'd0, b, o1, o2);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, b, o1, o2);
    check("reset_busy", {31'h0, b}, 32'h1);
    count_clear("clear_len_first");
    for (int k = 0; k < 32; k++) begin
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'(k), 5'(k), b, o1, o2);
      check("zero_rd1", o1, 32'h0);
      check("zero_rd2", o2, 32'h0);
    end

    step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, b, o1, o2);
    check("bypass_x5", o1, 32'hDEADBEEF);
    step(1'b1, 1'b0, 5'd5, 32'h0, 5'd5, 5'd0, b, o1, o2);
    check("array_x5", o1, 32'hDEADBEEF);

    step(1'b1, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, b, o1, o2);
    check("x0_byp1", o1, 32'h0);
    check("x0_byp2", o2, 32'h0);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, b, o1, o2);
    check("x0_arr1", o1, 32'h0);
    check("x0_arr2", o2, 32'h0);

    step(1'b1, 1'b1, 5'd1, 32'd1, 5'd1, 5'd2, b, o1, o2);
    check("b2b_a1", o1, 32'd1); check("b2b_a2", o2, 32'd0);
    step(1'b1, 1'b1, 5'd2, 32'd2, 5'd1, 5'd2, b, o1, o2);
    check("b2b_b1", o1, 32'd1); check("b2b_b2", o2, 32'd2);
    step(1'b1, 1'b1, 5'd1, 32'd3, 5'd1, 5'd2, b, o1, o2);
    check("b2b_c1", o1, 32'd3); check("b2b_c2", o2, 32'd2);

    step(1'b1, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, b, o1, o2);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, b, o1, o2);
    check("x7_pre", o1, 32'hA5A5A5A5);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, b, o1, o2);
    count_clear("clear_len_mid");
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd1, b, o1, o2);
    check("x7_cleared", o1, 32'h0);

    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, b, o1, o2);
    for (int i = 1; i < 10; i++)
      step(1'b1, i == 4, 5'd3, 32'h55, 5'd3, 5'd3, b, o1, o2);
    step(1'b0, 1'b1, 5'd3, 32'h55, 5'd3, 5'd3, b, o1, o2);
    count_clear("clear_len_restart");
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd10, b, o1, o2);
    check("x3_ignored", o1, 32'h0);

    for (int i = 0; i < 60; i++)
      step(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), b, o1, o2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
